vga_sync_rx: RTL and testbench

- Sink-side VGA timing decoder: consumes hsync/vsync from a VGA source and recovers the 11-bit pixel position (x, y), an active-video flag, measured line and frame lengths, and a lock indicator.
- Used on the loopback/monitor path to check the VGA driver's sync output.
- It produces the position counters that pixel logic compares against, instead of consuming them.

---
 rtl/vga_sync_rx.sv | 102 ++++++++++
 tb/tb_vga_sync_rx.sv | 135 +++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: decodes hsync/vsync (clk, rst, hsync_in, vsync_in) into x/y/active, frame_start, line_len, frame_lines and locked
module vga_sync_rx #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int H_ACT       = 640,
  parameter int V_ACT_START = 35,
  parameter int V_ACT       = 480,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        active,
  output logic        frame_start,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic        locked
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] LF = GW'(LOCK_FRAMES);
  localparam logic [10:0] MAX = 11'h7ff;
  localparam logic [10:0] HS0 = 11'(H_ACT_START);
  localparam logic [10:0] HS1 = 11'(H_ACT_START + H_ACT);
  localparam logic [10:0] VS0 = 11'(V_ACT_START);
  localparam logic [10:0] VS1 = 11'(V_ACT_START + V_ACT);
  logic hs, vs, hs_q, vs_q, hs_rise, vs_rise, fb, line_err, timeout, good, win;
  logic vs_pend_q, seen_h_q, seen_v_q, line_bad_q, active_q, frame_start_q, locked_q;
  logic [10:0] h_cnt_q, v_cnt_q, h_inc, v_inc, x_q, y_q, line_len_q, frame_lines_q;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  always_comb begin
    hs = hsync_in ~^ HS_POL;
    vs = vsync_in ~^ VS_POL;
    hs_rise = hs & ~hs_q;
    vs_rise = vs & ~vs_q;
    h_inc = h_cnt_q + 11'd1;
    v_inc = v_cnt_q + 11'd1;
    fb = hs_rise & (vs_pend_q | vs_rise);
    line_err = hs_rise & seen_h_q & (h_inc != 11'(H_TOTAL));
    timeout = (h_cnt_q == MAX) | (v_cnt_q == MAX);
    good = (v_inc == 11'(V_TOTAL)) & ~line_bad_q & ~line_err;
    good_cnt_d = (timeout | line_err) ? '0 :
                 (fb & seen_v_q) ? (good ? ((good_cnt_q == LF) ? LF : good_cnt_q + GW'(1)) : '0) :
                 good_cnt_q;
    win = (h_cnt_q >= HS0) & (h_cnt_q < HS1) & (v_cnt_q >= VS0) & (v_cnt_q < VS1) & locked_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      vs_pend_q <= 1'b0;
      seen_h_q <= 1'b0;
      seen_v_q <= 1'b0;
      line_bad_q <= 1'b0;
      good_cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      active_q <= 1'b0;
      frame_start_q <= 1'b0;
      line_len_q <= '0;
      frame_lines_q <= '0;
      locked_q <= 1'b0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;
      h_cnt_q <= hs_rise ? '0 : (h_cnt_q == MAX) ? MAX : h_inc;
      if (hs_rise) seen_h_q <= 1'b1;
      if (hs_rise & seen_h_q) line_len_q <= h_inc;
      frame_start_q <= fb;
      if (fb) begin
        v_cnt_q <= '0;
        vs_pend_q <= 1'b0;
        seen_v_q <= 1'b1;
        if (seen_v_q) frame_lines_q <= v_inc;
      end else begin
        if (vs_rise) vs_pend_q <= 1'b1;
        if (hs_rise) v_cnt_q <= (v_cnt_q == MAX) ? MAX : v_inc;
      end
      line_bad_q <= fb ? 1'b0 : (line_bad_q | line_err);
      good_cnt_q <= good_cnt_d;
      // next-state compare so a line error or timeout drops lock one cycle later
      locked_q <= (good_cnt_d == LF);
      active_q <= win;
      x_q <= win ? h_cnt_q - HS0 : '0;
      y_q <= win ? v_cnt_q - VS0 : '0;
    end
  end
  assign x = x_q;
  assign y = y_q;
  assign active = active_q;
  assign frame_start = frame_start_q;
  assign line_len = line_len_q;
  assign frame_lines = frame_lines_q;
  assign locked = locked_q;
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: scoreboard bench for vga_sync_rx on a scaled 40x12 timing
module tb_vga_sync_rx;
  logic clk = 1'b0;
  logic rst, hsync_in, vsync_in;
  logic [10:0] x, y, line_len, frame_lines;
  logic active, frame_start, locked;
  int total = 0;
  int bad = 0;
  typedef struct { int ll; int fl; int lk; } exp_t;
  exp_t sb[$];
  typedef struct { int v; int i; int act; int px; int py; } pos_t;
  pos_t pos_tab[7] = '{
    '{3, 9, 1, 0, 0}, '{3, 8, 0, 0, 0}, '{8, 32, 1, 23, 5}, '{8, 33, 0, 0, 0},
    '{2, 9, 0, 0, 0}, '{9, 9, 0, 0, 0}, '{5, 20, 1, 11, 2}};
  vga_sync_rx #(
    .H_TOTAL(40), .V_TOTAL(12), .H_ACT_START(8), .H_ACT(24),
    .V_ACT_START(3), .V_ACT(6), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .active(active), .frame_start(frame_start),
    .line_len(line_len), .frame_lines(frame_lines), .locked(locked)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " x"}, 32'(x), 0);
    chk({tag, " y"}, 32'(y), 0);
    chk({tag, " active"}, 32'(active), 0);
    chk({tag, " frame_start"}, 32'(frame_start), 0);
    chk({tag, " line_len"}, 32'(line_len), 0);
    chk({tag, " frame_lines"}, 32'(frame_lines), 0);
    chk({tag, " locked"}, 32'(locked), 0);
  endtask
  task automatic send_line(input int len, input int v, input bit pos,
                           input bit chk_first, input int f_ll, input int f_lk);
    for (int i = 0; i < len; i++) begin
      hsync_in = (i < 4) ? 1'b0 : 1'b1;
      vsync_in = (v < 2) ? 1'b0 : 1'b1;
      tick;
      if (chk_first && i == 0) begin
        chk("line_len at rise", 32'(line_len), 32'(f_ll));
        chk("locked at rise", 32'(locked), 32'(f_lk));
      end
      if (pos)
        foreach (pos_tab[k])
          if (pos_tab[k].v == v && pos_tab[k].i == i) begin
            chk("pos active", 32'(active), 32'(pos_tab[k].act));
            chk("pos x", 32'(x), 32'(pos_tab[k].px));
            chk("pos y", 32'(y), 32'(pos_tab[k].py));
          end
    end
  endtask
  task automatic send_frame(input int n, input int short_idx, input bit pos,
                            input int ll, input int fl, input int lk);
    sb.push_back('{ll, fl, lk});
    for (int v = 0; v < n; v++)
      send_line((v == short_idx) ? 39 : 40, v, pos,
                (short_idx >= 0) && (v == short_idx || v == short_idx + 1),
                (v == short_idx) ? 40 : 39, (v == short_idx) ? 1 : 0);
  endtask
  initial forever begin
    @(negedge clk);
    if (frame_start) begin
      if (sb.size() == 0) chk("frame_start unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("boundary line_len", 32'(line_len), 32'(e.ll));
        chk("boundary frame_lines", 32'(frame_lines), 32'(e.fl));
        chk("boundary locked", 32'(locked), 32'(e.lk));
      end
    end
  end
  initial begin
    int k;
    bit seen;
    rst = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) tick;
    chk_zero("reset");
    rst = 1'b0;
    repeat (3) tick;
    send_frame(12, -1, 1'b0, 0, 0, 0);
    send_frame(12, -1, 1'b0, 40, 12, 0);
    send_frame(12, -1, 1'b0, 40, 12, 1);
    send_frame(12, -1, 1'b1, 40, 12, 1);
    send_frame(12, 5, 1'b0, 40, 12, 1);
    send_frame(12, -1, 1'b0, 40, 12, 0);
    send_frame(12, -1, 1'b0, 40, 12, 0);
    send_frame(13, -1, 1'b0, 40, 12, 1);
    send_frame(12, -1, 1'b0, 40, 13, 0);
    send_frame(12, -1, 1'b0, 40, 12, 0);
    sb.push_back('{40, 12, 1});
    for (int v = 0; v < 5; v++) send_line(40, v, 1'b0, 1'b0, 0, 0);
    send_line(10, 5, 1'b0, 1'b0, 0, 0);
    chk("locked before mid reset", 32'(locked), 1);
    rst = 1'b1;
    tick;
    chk_zero("mid reset");
    rst = 1'b0;
    repeat (5) tick;
    send_frame(12, -1, 1'b0, 0, 0, 0);
    send_frame(12, -1, 1'b0, 40, 12, 0);
    send_frame(12, -1, 1'b0, 40, 12, 1);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    k = 39;
    seen = 1'b0;
    while (k < 3000 && !seen) begin
      tick;
      k++;
      if (!locked) seen = 1'b1;
    end
    chk("hsync loss edge", 32'(k), 2048);
    chk("hsync loss active", 32'(active), 0);
    chk("hsync loss x", 32'(x), 0);
    repeat (10) tick;
    chk("hsync loss held", 32'(locked), 0);
    repeat (5) tick;
    chk("scoreboard drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
